// File: rtl/tl_lamp_guard_pkg.sv
// Shared definitions for the lamp guard: one-hot light codes, fault cause
// encodings, guard states and a code legality helper.
package tl_pkg;

    localparam logic [2:0] GREEN = 3'b001;
    localparam logic [2:0] AMBER = 3'b010;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] OFF   = 3'b000;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        CONFLICT = 2'b01,
        ILLEGAL  = 2'b10,
        SKIP     = 2'b11
    } cause_t;

    typedef enum logic [1:0] {
        INIT,
        PASS,
        FLASH
    } state_t;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == GREEN) || (code == AMBER) || (code == RED);
    endfunction

endpackage

// File: rtl/tl_lamp_guard_if.sv
// Controller-side bus of the lamp guard: four light codes and the clear
// request in, registered lamp drives and fault status out.
interface tl_lamp_guard_if;

    logic [2:0] light_M1_in;
    logic [2:0] light_M2_in;
    logic [2:0] light_MT_in;
    logic [2:0] light_S_in;
    logic       clear_fault;
    logic [2:0] lamp_M1;
    logic [2:0] lamp_M2;
    logic [2:0] lamp_MT;
    logic [2:0] lamp_S;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] fault_count;

    modport master (
        output light_M1_in, light_M2_in, light_MT_in, light_S_in, clear_fault,
        input  lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code, fault_count
    );

    modport slave (
        input  light_M1_in, light_M2_in, light_MT_in, light_S_in, clear_fault,
        output lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code, fault_count
    );

endinterface

// File: rtl/tl_lamp_guard_conflict_check.sv
// Combinational safety checks on the current and previous light codes:
// illegal codes, conflicting greens, green-to-red without amber, and the
// prioritised cause (illegal > conflict > skip).
module tl_conflict_check
    import tl_pkg::*;
(
    input  logic [2:0] cur_m1,
    input  logic [2:0] cur_m2,
    input  logic [2:0] cur_mt,
    input  logic [2:0] cur_s,
    input  logic [2:0] prev_m1,
    input  logic [2:0] prev_m2,
    input  logic [2:0] prev_mt,
    input  logic [2:0] prev_s,
    output logic       illegal,
    output logic       conflict,
    output logic       skip,
    output cause_t     cause
);

    logic g_m1, g_m2, g_mt, g_s;

    // Evaluate all flags and pick the highest-priority cause.
    always_comb begin
        g_m1 = (cur_m1 == GREEN);
        g_m2 = (cur_m2 == GREEN);
        g_mt = (cur_mt == GREEN);
        g_s  = (cur_s  == GREEN);

        illegal  = !is_legal(cur_m1) || !is_legal(cur_m2) ||
                   !is_legal(cur_mt) || !is_legal(cur_s);
        // Only {M1,M2}, {M1,MT} and {S} may be green together.
        conflict = (g_m2 && g_mt) || (g_s && (g_m1 || g_m2 || g_mt));
        skip     = ((prev_m1 == GREEN) && (cur_m1 == RED)) ||
                   ((prev_m2 == GREEN) && (cur_m2 == RED)) ||
                   ((prev_mt == GREEN) && (cur_mt == RED)) ||
                   ((prev_s  == GREEN) && (cur_s  == RED));

        cause = NONE;
        if (illegal)       cause = ILLEGAL;
        else if (conflict) cause = CONFLICT;
        else if (skip)     cause = SKIP;
    end

endmodule

// File: rtl/tl_lamp_guard.sv
// Lamp safety guard between the traffic light controller and the lamp
// drivers. Holds all-red at startup, passes codes through with one cycle of
// latency, and latches a fault into flashing amber on a filtered static
// fault or an immediate amber-skip.
// Optional: define TL_GUARD_FAULT_LOG_EN to count trips on fault_count.
module tl_lamp_guard
    import tl_pkg::*;
#(
    parameter int STARTUP_CYCLES = 4,
    parameter int FILTER_CYCLES  = 2,
    parameter int FLASH_HALF     = 1,
    parameter int CNT_W          = 4
)(
    input  logic            clk,
    input  logic            rst,
    tl_lamp_guard_if.slave  bus
);

    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(FLASH_HALF - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] filt_cnt;
    logic             phase_on;
    logic [2:0]       lamp_m1, lamp_m2, lamp_mt, lamp_s;
    logic [2:0]       prev_m1, prev_m2, prev_mt, prev_s;
    logic             fault_q;
    cause_t           code_q;

    logic             illegal, conflict, skip, static_fault, trip;
    cause_t           cause;

    tl_conflict_check u_check (
        .cur_m1   (bus.light_M1_in),
        .cur_m2   (bus.light_M2_in),
        .cur_mt   (bus.light_MT_in),
        .cur_s    (bus.light_S_in),
        .prev_m1  (prev_m1),
        .prev_m2  (prev_m2),
        .prev_mt  (prev_mt),
        .prev_s   (prev_s),
        .illegal  (illegal),
        .conflict (conflict),
        .skip     (skip),
        .cause    (cause)
    );

    // Trip decision: static faults trip once filtered, skips trip at once.
    always_comb begin
        static_fault = illegal || conflict;
        trip         = 1'b0;
        if (state == PASS)
            trip = static_fault ? (filt_cnt == FILTER_LAST) : skip;
    end

    // Guard state machine with registered lamp drives and fault status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            cnt      <= '0;
            filt_cnt <= '0;
            phase_on <= 1'b0;
            lamp_m1  <= RED;
            lamp_m2  <= RED;
            lamp_mt  <= RED;
            lamp_s   <= RED;
            prev_m1  <= RED;
            prev_m2  <= RED;
            prev_mt  <= RED;
            prev_s   <= RED;
            fault_q  <= 1'b0;
            code_q   <= NONE;
        end else begin
            prev_m1 <= bus.light_M1_in;
            prev_m2 <= bus.light_M2_in;
            prev_mt <= bus.light_MT_in;
            prev_s  <= bus.light_S_in;
            case (state)
                INIT: begin
                    {lamp_m1, lamp_m2, lamp_mt, lamp_s} <= {RED, RED, RED, RED};
                    if (cnt == START_LAST) begin
                        state <= PASS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PASS: begin
                    if (trip) begin
                        {lamp_m1, lamp_m2, lamp_mt, lamp_s} <= {RED, RED, RED, RED};
                        fault_q  <= 1'b1;
                        code_q   <= cause;
                        state    <= FLASH;
                        phase_on <= 1'b1;
                        cnt      <= '0;
                        filt_cnt <= '0;
                    end else if (static_fault) begin
                        {lamp_m1, lamp_m2, lamp_mt, lamp_s} <= {RED, RED, RED, RED};
                        filt_cnt <= filt_cnt + 1'b1;
                    end else begin
                        lamp_m1  <= bus.light_M1_in;
                        lamp_m2  <= bus.light_M2_in;
                        lamp_mt  <= bus.light_MT_in;
                        lamp_s   <= bus.light_S_in;
                        filt_cnt <= '0;
                    end
                end
                FLASH: begin
                    if (bus.clear_fault) begin
                        {lamp_m1, lamp_m2, lamp_mt, lamp_s} <= {RED, RED, RED, RED};
                        fault_q <= 1'b0;
                        code_q  <= NONE;
                        state   <= INIT;
                        cnt     <= '0;
                    end else begin
                        {lamp_m1, lamp_m2, lamp_mt, lamp_s} <= phase_on ?
                            {AMBER, AMBER, AMBER, AMBER} : {OFF, OFF, OFF, OFF};
                        if (cnt == HALF_LAST) begin
                            phase_on <= !phase_on;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef TL_GUARD_FAULT_LOG_EN
    logic [7:0] trip_count;

    // Saturating trip counter, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            trip_count <= '0;
        else if (trip && (trip_count != 8'hFF))
            trip_count <= trip_count + 8'd1;
    end

    assign bus.fault_count = trip_count;
`else
    assign bus.fault_count = '0;
`endif

    assign bus.lamp_M1    = lamp_m1;
    assign bus.lamp_M2    = lamp_m2;
    assign bus.lamp_MT    = lamp_mt;
    assign bus.lamp_S     = lamp_s;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

endmodule

// File: tb/tb_tl_lamp_guard.sv
// Self-checking bench for tl_lamp_guard: directed scenarios plus a random
// phase, every cycle compared against a cycle-level model of the guard rules.
module tb_tl_lamp_guard;
    import tl_pkg::*;

    localparam int STARTUP = 4;
    localparam int FILTER  = 2;
    localparam int HALF    = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tl_lamp_guard_if bus();

    tl_lamp_guard #(
        .STARTUP_CYCLES (STARTUP),
        .FILTER_CYCLES  (FILTER),
        .FLASH_HALF     (HALF),
        .CNT_W          (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = startup hold, 1 = pass-through, 2 = flashing.
    int         m_mode;
    int         m_startup;
    int         m_bad;
    int         m_flash_age;
    int         m_trips;
    logic [2:0] m_lamp [4];
    logic [2:0] m_prev [4];
    logic       m_fault;
    logic [1:0] m_code;

    function automatic logic [11:0] lamps_obs();
        return {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_S};
    endfunction

    function automatic logic [22:0] obs();
        return {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_S,
                bus.fault, bus.fault_code, bus.fault_count};
    endfunction

    function automatic logic [22:0] expv();
        logic [7:0] c;
`ifdef TL_GUARD_FAULT_LOG_EN
        c = 8'(m_trips);
`else
        c = 8'h00;
`endif
        return {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3], m_fault, m_code, c};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_startup = 0; m_bad = 0; m_flash_age = 0; m_trips = 0;
        m_fault = 1'b0; m_code = 2'b00;
        for (int i = 0; i < 4; i++) begin
            m_lamp[i] = RED;
            m_prev[i] = RED;
        end
    endtask

    task automatic model_trip(input logic [1:0] code);
        for (int i = 0; i < 4; i++) m_lamp[i] = RED;
        m_fault = 1'b1;
        m_code = code;
        m_mode = 2;
        m_flash_age = 0;
        m_bad = 0;
        if (m_trips < 255) m_trips++;
    endtask

    task automatic model_step();
        logic [2:0] cur [4];
        bit ill, conf, skp;
        bit g [4];
        cur[0] = bus.light_M1_in; cur[1] = bus.light_M2_in;
        cur[2] = bus.light_MT_in; cur[3] = bus.light_S_in;
        ill = 0; skp = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(cur[i] inside {3'b001, 3'b010, 3'b100})) ill = 1;
            if (m_prev[i] == 3'b001 && cur[i] == 3'b100) skp = 1;
            g[i] = (cur[i] == 3'b001);
        end
        conf = (g[1] && g[2]) || (g[3] && (g[0] || g[1] || g[2]));
        case (m_mode)
            0: begin
                for (int i = 0; i < 4; i++) m_lamp[i] = RED;
                m_startup++;
                if (m_startup == STARTUP) m_mode = 1;
            end
            1: begin
                if (ill || conf) begin
                    m_bad++;
                    for (int i = 0; i < 4; i++) m_lamp[i] = RED;
                    if (m_bad >= FILTER) model_trip(ill ? 2'b10 : 2'b01);
                end else if (skp) begin
                    model_trip(2'b11);
                end else begin
                    m_bad = 0;
                    for (int i = 0; i < 4; i++) m_lamp[i] = cur[i];
                end
            end
            default: begin
                if (bus.clear_fault) begin
                    m_fault = 1'b0; m_code = 2'b00; m_mode = 0; m_startup = 0;
                    for (int i = 0; i < 4; i++) m_lamp[i] = RED;
                end else begin
                    for (int i = 0; i < 4; i++)
                        m_lamp[i] = (((m_flash_age / HALF) % 2) == 0) ? AMBER : OFF;
                    m_flash_age++;
                end
            end
        endcase
        for (int i = 0; i < 4; i++) m_prev[i] = cur[i];
    endtask

    task automatic drive(input logic [2:0] a, b, c, d);
        bus.light_M1_in = a; bus.light_M2_in = b;
        bus.light_MT_in = c; bus.light_S_in  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Clear pulse followed by the startup hold, inputs all red.
    task automatic clear_restart();
        drive(RED, RED, RED, RED);
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        repeat (STARTUP) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.clear_fault = 1'b0;
        drive(RED, RED, RED, RED);
        #2;
        model_reset();
        #1;
        if (obs() !== expv()) begin
            fails++; $display("FAIL reset_values: got %h want %h", obs(), expv());
        end
        tests++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < STARTUP; i++) begin
            tick();
            if (obs() !== expv()) begin
                fails++; $display("FAIL startup_hold[%0d]: got %h want %h", i, obs(), expv());
            end
            tests++;
        end
        if (lamps_obs() !== 12'h924) begin
            fails++; $display("FAIL startup_red: got %h want 924", lamps_obs());
        end
        tests++;
    endtask

    task automatic test_controller_cycle();
        logic [11:0] ph_code [6];
        int ph_len [6];
        logic [11:0] code;
        ph_code = '{{GREEN, GREEN, RED, RED}, {GREEN, AMBER, RED, RED},
                    {GREEN, RED, GREEN, RED}, {AMBER, RED, AMBER, RED},
                    {RED, RED, RED, GREEN},   {RED, RED, RED, AMBER}};
        ph_len = '{8, 3, 6, 3, 4, 8};
        for (int p = 0; p < 6; p++) begin
            code = ph_code[p];
            drive(code[11:9], code[8:6], code[5:3], code[2:0]);
            for (int k = 0; k < ph_len[p]; k++) begin
                tick();
                if (obs() !== expv()) begin
                    fails++; $display("FAIL cycle_p%0d_%0d: got %h want %h", p, k, obs(), expv());
                end
                tests++;
            end
            if (lamps_obs() !== code || bus.fault !== 1'b0) begin
                fails++; $display("FAIL pass_through_p%0d: got %h/%b want %h/0", p, lamps_obs(), bus.fault, code);
            end
            tests++;
        end
    endtask

    task automatic test_conflict_filter();
        drive(RED, RED, RED, RED);
        tick();
        drive(RED, GREEN, GREEN, RED);
        tick();
        if (lamps_obs() !== 12'h924 || bus.fault !== 1'b0) begin
            fails++; $display("FAIL conflict_1cyc: got %h/%b want 924/0", lamps_obs(), bus.fault);
        end
        tests++;
        drive(RED, AMBER, AMBER, RED);
        tick();
        drive(RED, RED, RED, RED);
        tick();
        if (obs() !== expv()) begin
            fails++; $display("FAIL conflict_recover: got %h want %h", obs(), expv());
        end
        tests++;
        drive(RED, GREEN, GREEN, RED);
        repeat (2) tick();
        if (bus.fault !== 1'b1 || bus.fault_code !== 2'b01) begin
            fails++; $display("FAIL conflict_trip: got %b/%b want 1/01", bus.fault, bus.fault_code);
        end
        tests++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (lamps_obs() !== ((k % 2 == 0) ? 12'h492 : 12'h000)) begin
                fails++; $display("FAIL flash_phase[%0d]: got %h", k, lamps_obs());
            end
            tests++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL flash_model[%0d]: got %h want %h", k, obs(), expv());
            end
            tests++;
        end
        clear_restart();
        if (obs() !== expv() || bus.fault !== 1'b0) begin
            fails++; $display("FAIL clear_hold: got %h want %h", obs(), expv());
        end
        tests++;
        drive(GREEN, GREEN, RED, RED);
        tick();
        if (lamps_obs() !== {GREEN, GREEN, RED, RED}) begin
            fails++; $display("FAIL clear_resume: got %h", lamps_obs());
        end
        tests++;
    endtask

    task automatic test_illegal_priority();
        drive(3'b011, RED, RED, RED);
        repeat (2) tick();
        if (bus.fault !== 1'b1 || bus.fault_code !== 2'b10) begin
            fails++; $display("FAIL illegal_trip: got %b/%b want 1/10", bus.fault, bus.fault_code);
        end
        tests++;
        clear_restart();
        drive(3'b011, GREEN, RED, GREEN);
        repeat (2) tick();
        if (bus.fault_code !== 2'b10 || obs() !== expv()) begin
            fails++; $display("FAIL illegal_over_conflict: got %h want %h", obs(), expv());
        end
        tests++;
        clear_restart();
    endtask

    task automatic test_skip();
        drive(GREEN, GREEN, RED, RED);
        tick();
        drive(RED, GREEN, RED, RED);
        tick();
        if (lamps_obs() !== 12'h924 || bus.fault !== 1'b1 || bus.fault_code !== 2'b11) begin
            fails++; $display("FAIL skip_trip: got %h/%b/%b want 924/1/11", lamps_obs(), bus.fault, bus.fault_code);
        end
        tests++;
        clear_restart();
    endtask

    task automatic test_clear_in_pass();
        drive(GREEN, GREEN, RED, RED);
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        if (lamps_obs() !== {GREEN, GREEN, RED, RED} || bus.fault !== 1'b0) begin
            fails++; $display("FAIL clear_in_pass: got %h/%b", lamps_obs(), bus.fault);
        end
        tests++;
        drive(AMBER, AMBER, RED, RED);
        tick();
        drive(RED, RED, RED, RED);
        tick();
        if (obs() !== expv()) begin
            fails++; $display("FAIL clear_in_pass_after: got %h want %h", obs(), expv());
        end
        tests++;
    endtask

    task automatic test_random();
        logic [2:0] c [4];
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 15) == 0) c[i] = 3'($urandom_range(0, 7));
                else case ($urandom_range(0, 2))
                    0: c[i] = GREEN;
                    1: c[i] = AMBER;
                    default: c[i] = RED;
                endcase
            end
            drive(c[0], c[1], c[2], c[3]);
            bus.clear_fault = ($urandom_range(0, 7) == 0);
            tick();
            if (obs() !== expv()) begin
                fails++; $display("FAIL random[%0d]: got %h want %h", n, obs(), expv());
            end
            tests++;
        end
        bus.clear_fault = 1'b0;
    endtask

    task automatic test_rst_mid_flash();
        rst = 1'b1; drive(RED, RED, RED, RED); #2; model_reset(); @(posedge clk); #1;
        rst = 1'b0;
        repeat (STARTUP) tick();
        drive(RED, GREEN, GREEN, RED);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        if (lamps_obs() !== 12'h924 || bus.fault !== 1'b0 || obs() !== expv()) begin
            fails++; $display("FAIL rst_mid_flash: got %h want %h", obs(), expv());
        end
        tests++;
        drive(RED, RED, RED, RED);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (STARTUP) tick();
    endtask

    task automatic test_fault_log();
        logic [7:0] want;
        for (int t = 0; t < 3; t++) begin
            drive(GREEN, RED, RED, RED);
            tick();
            drive(RED, RED, RED, RED);
            tick();
            if (t < 2) clear_restart();
        end
`ifdef TL_GUARD_FAULT_LOG_EN
        want = 8'd3;
`else
        want = 8'd0;
`endif
        if (bus.fault_count !== want) begin
            fails++; $display("FAIL fault_count_3: got %0d want %0d", bus.fault_count, want);
        end
        tests++;
        clear_restart();
        if (bus.fault_count !== want || bus.fault !== 1'b0) begin
            fails++; $display("FAIL fault_count_clear: got %0d want %0d", bus.fault_count, want);
        end
        tests++;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        if (bus.fault_count !== 8'd0 || obs() !== expv()) begin
            fails++; $display("FAIL fault_count_rst: got %0d want 0", bus.fault_count);
        end
        tests++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_controller_cycle();
        test_conflict_filter();
        test_illegal_priority();
        test_skip();
        test_clear_in_pass();
        test_random();
        test_rst_mid_flash();
        test_fault_log();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
